// File: rtl/clock_pkg.sv
// Shared types, BCD field limits and helpers for the timekeeping core.
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t SEC_MAX   = 8'h59;
    localparam bcd8_t MIN_MAX   = 8'h59;
    localparam bcd8_t HOUR_MAX  = 8'h23;
    localparam bcd8_t HOUR_NOON = 8'h12;

    localparam int unsigned DOW_W   = 3;
    localparam logic [2:0]  DOW_MAX = 3'd6;

    // Result of a BCD increment: next value plus a wrap (carry-out) flag.
    typedef struct packed {
        bcd8_t val;
        logic  wrap;
    } bcd_step_t;

    // Time-of-day register payload, all fields BCD.
    typedef struct packed {
        bcd8_t hour;
        bcd8_t min;
        bcd8_t sec;
    } tod_t;

    // Increment a two-digit BCD value, wrapping to 00 after max.
    function automatic bcd_step_t bcd_inc_wrap(input bcd8_t val, input bcd8_t max);
        bcd_step_t r;
        r.wrap = 1'b0;
        if (val == max) begin
            r.val  = 8'h00;
            r.wrap = 1'b1;
        end else if (val[3:0] == 4'h9) begin
            r.val = {val[7:4] + 4'h1, 4'h0};
        end else begin
            r.val = {val[7:4], val[3:0] + 4'h1};
        end
        return r;
    endfunction

    // Map an internal 00-23 BCD hour onto the 12 h display range 01-12.
    function automatic bcd8_t hour_24_to_12(input bcd8_t h);
        bcd8_t r;
        case (h)
            8'h00:   r = 8'h12;
            8'h13:   r = 8'h01;
            8'h14:   r = 8'h02;
            8'h15:   r = 8'h03;
            8'h16:   r = 8'h04;
            8'h17:   r = 8'h05;
            8'h18:   r = 8'h06;
            8'h19:   r = 8'h07;
            8'h20:   r = 8'h08;
            8'h21:   r = 8'h09;
            8'h22:   r = 8'h10;
            8'h23:   r = 8'h11;
            default: r = h;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_core_if.sv
// Control/display bundle between the DigitalClock top and time_core.
// Optional day-of-week signals exist only when TIME_CORE_DAY_EN is defined.
interface time_core_if;
    import clock_pkg::*;

    logic  run;
    logic  inc_hour;
    logic  inc_min;
    logic  inc_sec;
    logic  h12_mode;
    bcd8_t hour_bcd;
    bcd8_t min_bcd;
    bcd8_t sec_bcd;
    logic  pm;
    logic  sec_tick;
    logic  day_wrap;
`ifdef TIME_CORE_DAY_EN
    logic             inc_dow;
    logic [DOW_W-1:0] dow;
`endif

`ifdef TIME_CORE_DAY_EN
    modport master (
        output run, inc_hour, inc_min, inc_sec, h12_mode, inc_dow,
        input  hour_bcd, min_bcd, sec_bcd, pm, sec_tick, day_wrap, dow
    );
    modport slave (
        input  run, inc_hour, inc_min, inc_sec, h12_mode, inc_dow,
        output hour_bcd, min_bcd, sec_bcd, pm, sec_tick, day_wrap, dow
    );
`else
    modport master (
        output run, inc_hour, inc_min, inc_sec, h12_mode,
        input  hour_bcd, min_bcd, sec_bcd, pm, sec_tick, day_wrap
    );
    modport slave (
        input  run, inc_hour, inc_min, inc_sec, h12_mode,
        output hour_bcd, min_bcd, sec_bcd, pm, sec_tick, day_wrap
    );
`endif

endinterface

// File: rtl/btn_repeat.sv
// Set-button front end: rising-edge detect plus hold/auto-repeat counter.
// inc_c is a same-cycle pulse; the owner applies it on the current edge.
module btn_repeat #(
    parameter int unsigned HOLD_DLY = 500,
    parameter int unsigned HOLD_RPT = 100
) (
    input  logic clk_1k,
    input  logic clr_sw,
    input  logic btn_i,
    output logic inc_c
);

    localparam int unsigned HOLD_MAX = (HOLD_DLY > HOLD_RPT) ? HOLD_DLY : HOLD_RPT;
    localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1);

    logic prev_q;
    logic rise_c;

    assign rise_c = btn_i & ~prev_q;

    // Previous-level register; reset loads the live level so a held button needs a fresh press.
    always_ff @(posedge clk_1k) begin
        if (clr_sw) begin
            prev_q <= btn_i;
        end else begin
            prev_q <= btn_i;
        end
    end

    generate
        if (HOLD_DLY == 0) begin : g_no_rpt
            assign inc_c = rise_c;
        end else begin : g_rpt
            // cnt_q == 0 means disarmed; otherwise it counts cycles in the current phase.
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             rpt_q, rpt_d;
            logic             fire_c;

            // Hold/repeat next-state: delay phase first, then fixed-period repeat phase.
            always_comb begin
                cnt_d  = cnt_q;
                rpt_d  = rpt_q;
                fire_c = 1'b0;
                if (!btn_i) begin
                    cnt_d = '0;
                    rpt_d = 1'b0;
                end else if (rise_c) begin
                    cnt_d = CNT_W'(1);
                    rpt_d = 1'b0;
                end else if (cnt_q != '0) begin
                    if (!rpt_q && (cnt_q == CNT_W'(HOLD_DLY))) begin
                        fire_c = 1'b1;
                        cnt_d  = CNT_W'(1);
                        rpt_d  = 1'b1;
                    end else if (rpt_q && (cnt_q == CNT_W'(HOLD_RPT))) begin
                        fire_c = 1'b1;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Hold counter registers; reset cancels any hold in progress.
            always_ff @(posedge clk_1k) begin
                if (clr_sw) begin
                    cnt_q <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    rpt_q <= rpt_d;
                end
            end

            assign inc_c = rise_c | fire_c;
        end
    endgenerate

endmodule

// File: rtl/time_core.sv
// Timekeeping core: prescaler -> seconds tick -> BCD sec/min/hour with carry,
// set buttons with auto-repeat, 12/24 h display mapping and a day-wrap pulse.
// Optional day-of-week counter and button when TIME_CORE_DAY_EN is defined.
module time_core
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned PRE_W         = 10,
    parameter int unsigned HOLD_DLY      = 500,
    parameter int unsigned HOLD_RPT      = 100
) (
    input  logic         clk_1k,
    input  logic         clr_sw,
    time_core_if.slave   bus
);

    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    tod_t             tod_q, tod_d;
    logic             sec_tick_q, sec_tick_d;
    logic             day_wrap_q, day_wrap_d;

    logic      inc_hour_c, inc_min_c, inc_sec_c;
    logic      term_c, set_any_c, tick_c;
    bcd_step_t sec_step_c, min_step_c, hour_step_c;

`ifdef TIME_CORE_DAY_EN
    logic [DOW_W-1:0] dow_q, dow_d;
    logic             inc_dow_c;
    logic [DOW_W-1:0] dow_next_c;
`endif

    btn_repeat #(.HOLD_DLY(HOLD_DLY), .HOLD_RPT(HOLD_RPT)) u_btn_hour (
        .clk_1k (clk_1k),
        .clr_sw (clr_sw),
        .btn_i  (bus.inc_hour),
        .inc_c  (inc_hour_c)
    );

    btn_repeat #(.HOLD_DLY(HOLD_DLY), .HOLD_RPT(HOLD_RPT)) u_btn_min (
        .clk_1k (clk_1k),
        .clr_sw (clr_sw),
        .btn_i  (bus.inc_min),
        .inc_c  (inc_min_c)
    );

    btn_repeat #(.HOLD_DLY(HOLD_DLY), .HOLD_RPT(HOLD_RPT)) u_btn_sec (
        .clk_1k (clk_1k),
        .clr_sw (clr_sw),
        .btn_i  (bus.inc_sec),
        .inc_c  (inc_sec_c)
    );

`ifdef TIME_CORE_DAY_EN
    btn_repeat #(.HOLD_DLY(HOLD_DLY), .HOLD_RPT(HOLD_RPT)) u_btn_dow (
        .clk_1k (clk_1k),
        .clr_sw (clr_sw),
        .btn_i  (bus.inc_dow),
        .inc_c  (inc_dow_c)
    );

    assign dow_next_c = (dow_q == DOW_MAX) ? '0 : dow_q + DOW_W'(1);
    assign set_any_c  = inc_hour_c | inc_min_c | inc_sec_c | inc_dow_c;
`else
    assign set_any_c  = inc_hour_c | inc_min_c | inc_sec_c;
`endif

    // A pending set increment defers the tick by one cycle; the prescaler holds at terminal.
    assign term_c = bus.run & (pre_q == PRE_TERM);
    assign tick_c = term_c & ~set_any_c;

    assign sec_step_c  = bcd_inc_wrap(tod_q.sec,  SEC_MAX);
    assign min_step_c  = bcd_inc_wrap(tod_q.min,  MIN_MAX);
    assign hour_step_c = bcd_inc_wrap(tod_q.hour, HOUR_MAX);

    // Next-state: tick with carry chain, otherwise prescaler count and carry-free set increments.
    always_comb begin
        pre_d      = pre_q;
        tod_d      = tod_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
`ifdef TIME_CORE_DAY_EN
        dow_d      = dow_q;
`endif
        if (tick_c) begin
            pre_d      = '0;
            sec_tick_d = 1'b1;
            tod_d.sec  = sec_step_c.val;
            if (sec_step_c.wrap) begin
                tod_d.min = min_step_c.val;
                if (min_step_c.wrap) begin
                    tod_d.hour = hour_step_c.val;
                    day_wrap_d = hour_step_c.wrap;
                end
            end
`ifdef TIME_CORE_DAY_EN
            if (day_wrap_d) begin
                dow_d = dow_next_c;
            end
`endif
        end else begin
            if (bus.run && !term_c) begin
                pre_d = pre_q + PRE_W'(1);
            end
            if (inc_sec_c) begin
                tod_d.sec = sec_step_c.val;
            end
            if (inc_min_c) begin
                tod_d.min = min_step_c.val;
            end
            if (inc_hour_c) begin
                tod_d.hour = hour_step_c.val;
            end
`ifdef TIME_CORE_DAY_EN
            if (inc_dow_c) begin
                dow_d = dow_next_c;
            end
`endif
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk_1k) begin
        if (clr_sw) begin
            pre_q      <= '0;
            tod_q      <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
`ifdef TIME_CORE_DAY_EN
            dow_q      <= '0;
`endif
        end else begin
            pre_q      <= pre_d;
            tod_q      <= tod_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
`ifdef TIME_CORE_DAY_EN
            dow_q      <= dow_d;
`endif
        end
    end

    // Display mapping is combinational from registers; h12_mode only changes the view.
    assign bus.hour_bcd = bus.h12_mode ? hour_24_to_12(tod_q.hour) : tod_q.hour;
    assign bus.min_bcd  = tod_q.min;
    assign bus.sec_bcd  = tod_q.sec;
    assign bus.pm       = (tod_q.hour >= HOUR_NOON);
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_wrap = day_wrap_q;
`ifdef TIME_CORE_DAY_EN
    assign bus.dow      = dow_q;
`endif

endmodule

// File: tb/tb_time_core.sv
// Self-checking bench for time_core: directed scenarios plus random stimulus,
// all compared every cycle against a seconds-of-day reference model.
module tb_time_core;

    localparam int unsigned T  = 10;
    localparam int unsigned PW = 4;
    localparam int unsigned HD = 20;
    localparam int unsigned HR = 5;
`ifdef TIME_CORE_DAY_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic          clk_1k = 1'b0;
    logic          clr_sw;
    logic          run;
    logic          h12;
    logic [NB-1:0] btn;

    int n_checks = 0;
    int n_fail   = 0;

    time_core_if bus();

    assign bus.run      = run;
    assign bus.h12_mode = h12;
    assign bus.inc_hour = btn[0];
    assign bus.inc_min  = btn[1];
    assign bus.inc_sec  = btn[2];
`ifdef TIME_CORE_DAY_EN
    assign bus.inc_dow  = btn[3];
`endif

    time_core #(
        .TICKS_PER_SEC (T),
        .PRE_W         (PW),
        .HOLD_DLY      (HD),
        .HOLD_RPT      (HR)
    ) dut (
        .clk_1k (clk_1k),
        .clr_sw (clr_sw),
        .bus    (bus)
    );

    always #5 clk_1k = ~clk_1k;

    // Reference model state: time as seconds of day, buttons as press lengths.
    int m_pre, m_tod, m_dow;
    bit m_tick, m_wrap;
    bit m_prev[4];
    bit m_armed[4];
    int m_len[4];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_edge();
        bit inc[4];
        bit any;
        int h, mi, s;
        if (clr_sw) begin
            m_pre = 0; m_tod = 0; m_dow = 0; m_tick = 0; m_wrap = 0;
            for (int i = 0; i < 4; i++) begin
                m_prev[i]  = (i < NB) ? btn[i] : 1'b0;
                m_armed[i] = 0;
                m_len[i]   = 0;
            end
        end else begin
            any = 0;
            for (int i = 0; i < 4; i++) begin
                inc[i] = 0;
                if (i < NB) begin
                    if (!btn[i]) begin
                        m_armed[i] = 0;
                    end else if (!m_prev[i]) begin
                        m_armed[i] = 1; m_len[i] = 0; inc[i] = 1;
                    end else if (m_armed[i]) begin
                        m_len[i]++;
                        if (m_len[i] >= int'(HD) && ((m_len[i] - int'(HD)) % int'(HR)) == 0)
                            inc[i] = 1;
                    end
                    m_prev[i] = btn[i];
                    any = any | inc[i];
                end
            end
            m_tick = run && (m_pre == int'(T) - 1) && !any;
            m_wrap = 0;
            if (m_tick) begin
                m_wrap = (m_tod == 86399);
                m_tod  = (m_tod + 1) % 86400;
                if (m_wrap) m_dow = (m_dow + 1) % 7;
                m_pre = 0;
            end else begin
                if (run && m_pre != int'(T) - 1) m_pre++;
                h  = m_tod / 3600;
                mi = (m_tod / 60) % 60;
                s  = m_tod % 60;
                if (inc[0]) h  = (h + 1) % 24;
                if (inc[1]) mi = (mi + 1) % 60;
                if (inc[2]) s  = (s + 1) % 60;
                if (inc[3]) m_dow = (m_dow + 1) % 7;
                m_tod = h * 3600 + mi * 60 + s;
            end
        end
    endtask

    task automatic compare_all();
        int h, disp;
        h    = m_tod / 3600;
        disp = !h12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        check("hour_bcd", bus.hour_bcd, to_bcd(disp));
        check("min_bcd",  bus.min_bcd,  to_bcd((m_tod / 60) % 60));
        check("sec_bcd",  bus.sec_bcd,  to_bcd(m_tod % 60));
        check("pm",       8'(bus.pm),       8'(h >= 12));
        check("sec_tick", 8'(bus.sec_tick), 8'(m_tick));
        check("day_wrap", 8'(bus.day_wrap), 8'(m_wrap));
`ifdef TIME_CORE_DAY_EN
        check("dow",      8'(bus.dow),      8'(m_dow));
`endif
    endtask

    task automatic step();
        @(posedge clk_1k);
        model_edge();
        @(negedge clk_1k);
        compare_all();
    endtask

    task automatic press(input int idx, input int hi, input int lo);
        btn[idx] = 1'b1;
        repeat (hi) step();
        btn[idx] = 1'b0;
        repeat (lo) step();
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({tag, "_h"}, bus.hour_bcd, h);
        check({tag, "_m"}, bus.min_bcd,  m);
        check({tag, "_s"}, bus.sec_bcd,  s);
    endtask

    task automatic pulse_reset();
        clr_sw = 1'b1;
        step();
        clr_sw = 1'b0;
    endtask

    int          tgt[4]  = '{0, 12, 13, 23};
    logic [7:0]  e12[4]  = '{8'h12, 8'h12, 8'h01, 8'h11};
    logic [7:0]  e24[4]  = '{8'h00, 8'h12, 8'h13, 8'h23};
    logic        epm[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int cur;
        clr_sw = 1'b1; run = 1'b0; h12 = 1'b0; btn = '0;
        m_pre = 0; m_tod = 0; m_dow = 0; m_tick = 0; m_wrap = 0;
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = 0; m_armed[i] = 0; m_len[i] = 0;
        end

        // Reset values in both display modes
        step(); step();
        check_time("rst24", 8'h00, 8'h00, 8'h00);
        h12 = 1'b1;
        step();
        check("rst_hour12", bus.hour_bcd, 8'h12);
        check("rst_pm", 8'(bus.pm), 8'h00);
        h12 = 1'b0;
        clr_sw = 1'b0;

        // Manual set with run=0: no carry on set wrap
        repeat (23) press(0, 10, 5);
        repeat (59) press(1, 10, 5);
        repeat (58) press(2, 10, 5);
        check_time("set_58", 8'h23, 8'h59, 8'h58);
        press(2, 10, 5);
        check_time("set_59", 8'h23, 8'h59, 8'h59);
        press(2, 10, 5);
        check_time("set_wrap", 8'h23, 8'h59, 8'h00);
        repeat (58) press(2, 10, 5);
        check_time("set_58b", 8'h23, 8'h59, 8'h58);

        // Ticking across midnight
        run = 1'b1;
        repeat (9) step();
        check("tick1_early", 8'(bus.sec_tick), 8'h00);
        step();
        check("tick1", 8'(bus.sec_tick), 8'h01);
        check_time("t59", 8'h23, 8'h59, 8'h59);
        repeat (10) step();
        check("day_wrap_hi", 8'(bus.day_wrap), 8'h01);
        check("tick2", 8'(bus.sec_tick), 8'h01);
        check_time("midnight", 8'h00, 8'h00, 8'h00);
        step();
        check("day_wrap_lo", 8'(bus.day_wrap), 8'h00);

        // Set increment colliding with prescaler terminal count
        repeat (49) step();
        check_time("at05", 8'h00, 8'h00, 8'h05);
        repeat (9) step();
        btn[2] = 1'b1;
        step();
        check_time("coll06", 8'h00, 8'h00, 8'h06);
        check("coll_notick", 8'(bus.sec_tick), 8'h00);
        btn[2] = 1'b0;
        step();
        check_time("coll07", 8'h00, 8'h00, 8'h07);
        check("coll_tick", 8'(bus.sec_tick), 8'h01);
        repeat (9) step();
        check("coll_gap", 8'(bus.sec_tick), 8'h00);
        step();
        check("coll_next", 8'(bus.sec_tick), 8'h01);
        check_time("coll08", 8'h00, 8'h00, 8'h08);

        // Auto-repeat: 41 held cycles give 1 + 5 increments
        run = 1'b0;
        pulse_reset();
        btn[1] = 1'b1;
        repeat (41) step();
        btn[1] = 1'b0;
        step();
        check("rpt_min", bus.min_bcd, 8'h06);

        // 12/24 h display mapping
        pulse_reset();
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            while (cur < tgt[k]) begin
                press(0, 10, 5);
                cur++;
            end
            h12 = 1'b1;
            step();
            check("h12_hour", bus.hour_bcd, e12[k]);
            check("h12_pm", 8'(bus.pm), 8'(epm[k]));
            h12 = 1'b0;
            step();
            check("h24_hour", bus.hour_bcd, e24[k]);
        end

        // Reset mid-hold at 12:34:56 with run=1
        pulse_reset();
        repeat (11) press(0, 10, 5);
        repeat (34) press(1, 10, 5);
        repeat (56) press(2, 10, 5);
        run = 1'b1;
        btn[0] = 1'b1;
        repeat (5) step();
        check_time("hold_pre", 8'h12, 8'h34, 8'h56);
        clr_sw = 1'b1;
        step();
        clr_sw = 1'b0;
        check_time("hold_rst", 8'h00, 8'h00, 8'h00);
        check("hold_rst_tick", 8'(bus.sec_tick), 8'h00);
        repeat (40) step();
        check("hold_norpt", bus.hour_bcd, 8'h00);
        btn[0] = 1'b0;
        step();
        btn[0] = 1'b1;
        step();
        check("hold_repress", bus.hour_bcd, 8'h01);
        btn[0] = 1'b0;
        step();

        // Random stimulus against the model
        run = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            clr_sw = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 31) == 0) run = ~run;
            if ($urandom_range(0, 39) == 0) h12 = ~h12;
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
